cond_unit_banked: RTL and testbench

Pipelined, parametrised condition unit for the pipelined ARMv4 core. It evaluates the 4-bit ARM condition field against one of NUM_BANKS banked NZCV flag sets, gates PCSrc/RegWrite/MemWrite, and updates the selected bank. The block has one output register stage with stall/flush control, flags the reserved condition 4'b1111 as illegal, and keeps a saturating count of squashed instructions. It sits between decode/execute and the memory stage, in place of the single-bank unpipelined conditional logic.

---
 rtl/cond_pkg.sv | 36 +++
 rtl/cond_check.sv | 43 ++++
 rtl/cond_unit_banked.sv | 138 +++++++++++++
 tb/tb_cond_unit_banked.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition-code types for the banked condition unit
//
// Purpose: ARM condition field encoding, NZCV flag record and flag width,
//          shared by cond_check, cond_unit_banked and verification models.
// Ports:   none (package).
package cond_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition evaluation against one NZCV set
//
// Purpose: decide whether an instruction with condition field cond executes
//          given flags; the reserved encoding is reported as illegal.
// Ports:
//   flags   in  nzcv_t  flag set to evaluate against
//   cond    in  cond_e  ARM condition field
//   ex      out 1       condition passed (always 0 for the reserved encoding)
//   illegal out 1       cond is the reserved encoding 4'b1111
module cond_check
  import cond_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  ex,
  output logic  illegal
);

  always_comb begin
    ex      = 1'b0;
    illegal = 1'b0;
    case (cond)
      EQ: ex = flags.z;
      NE: ex = ~flags.z;
      CS: ex = flags.c;
      CC: ex = ~flags.c;
      MI: ex = flags.n;
      PL: ex = ~flags.n;
      VS: ex = flags.v;
      VC: ex = ~flags.v;
      HI: ex = flags.c & ~flags.z;
      LS: ex = ~flags.c | flags.z;
      GE: ex = (flags.n == flags.v);
      LT: ex = (flags.n != flags.v);
      GT: ex = ~flags.z & (flags.n == flags.v);
      LE: ex = flags.z | (flags.n != flags.v);
      AL: ex = 1'b1;
      NV: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit_banked.sv
// rtl/cond_unit_banked.sv - pipelined condition unit with banked NZCV flags
//
// Purpose: evaluates the ARM condition field against the selected flag bank,
//          gates PC-source / register-write / memory-write requests, updates the
//          selected bank and registers the result with stall/flush control.
//          Keeps a saturating count of condition-failed (squashed) instructions.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   valid_in            instruction present on the inputs
//   stall, flush        hold everything / kill incoming and clear output stage
//   bank_sel            flag bank used for evaluation and update
//   pcs, reg_w, mem_w   decoded requests to be gated by the condition
//   flag_w              [1] write N,Z  [0] write C,V
//   cond, alu_flags     condition field and ALU {N,Z,C,V}
//   valid_out, pc_src, reg_write, mem_write, cond_ex, illegal   registered results
//   flags_out           combinational NZCV of the selected bank (0 if out of range)
//   squash_cnt          saturating squash counter
module cond_unit_banked
  import cond_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int CNT_W     = 16,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              pcs,
  input  logic              reg_w,
  input  logic              mem_w,
  input  logic [1:0]        flag_w,
  input  logic [3:0]        cond,
  input  logic [3:0]        alu_flags,
  output logic              valid_out,
  output logic              pc_src,
  output logic              reg_write,
  output logic              mem_write,
  output logic              cond_ex,
  output logic              illegal,
  output logic [3:0]        flags_out,
  output logic [CNT_W-1:0]  squash_cnt
);

  nzcv_t            bank_q [NUM_BANKS];
  nzcv_t            cur_flags;
  logic             bank_ok;
  logic             chk_ex;
  logic             chk_ill;
  logic             ex;
  logic             ill;
  logic             accept;
  logic [CNT_W-1:0] squash_q;

  assign bank_ok = (int'(bank_sel) < NUM_BANKS);

  // Explicit select loop so an out-of-range bank_sel reads as all-zero flags
  // instead of indexing past the array.
  always_comb begin
    cur_flags = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (BANK_W'(i) == bank_sel) cur_flags = bank_q[i];
    end
  end

  assign flags_out = cur_flags;

  cond_check u_check (
    .flags   (cur_flags),
    .cond    (cond_e'(cond)),
    .ex      (chk_ex),
    .illegal (chk_ill)
  );

  assign ex     = chk_ex & bank_ok;
  assign ill    = chk_ill | ~bank_ok;
  assign accept = valid_in & ~stall & ~flush;

  // Output stage: flush beats stall; an idle cycle clears the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      pc_src    <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      cond_ex   <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
      pc_src    <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      cond_ex   <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      valid_out <= valid_in;
      pc_src    <= valid_in & pcs & ex;
      reg_write <= valid_in & reg_w & ex;
      mem_write <= valid_in & mem_w & ex;
      cond_ex   <= valid_in & ex;
      illegal   <= valid_in & ill;
    end
  end

  // Flag banks: only the selected bank is written, per half, and only when the
  // instruction is accepted and its condition passed (ex is 0 for illegal).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (accept && ex && (BANK_W'(i) == bank_sel)) begin
          if (flag_w[1]) begin
            bank_q[i].n <= alu_flags[3];
            bank_q[i].z <= alu_flags[2];
          end
          if (flag_w[0]) begin
            bank_q[i].c <= alu_flags[1];
            bank_q[i].v <= alu_flags[0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_q <= '0;
    end else if (accept && !ex && !ill && (squash_q != {CNT_W{1'b1}})) begin
      squash_q <= squash_q + 1'b1;
    end
  end

  assign squash_cnt = squash_q;

endmodule

// File: tb/tb_cond_unit_banked.sv
// tb/tb_cond_unit_banked.sv - self-checking bench for cond_unit_banked
module tb_cond_unit_banked;

  localparam int NB = 3;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 0, stall = 0, flush = 0;
  logic [1:0] bank_sel = 0;
  logic       pcs = 0, reg_w = 0, mem_w = 0;
  logic [1:0] flag_w = 0;
  logic [3:0] cond = 0, alu_flags = 0;
  logic       valid_out, pc_src, reg_write, mem_write, cond_ex, illegal;
  logic [3:0] flags_out;
  logic [CW-1:0] squash_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 0;

  cond_unit_banked #(.NUM_BANKS(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
    .bank_sel(bank_sel), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
    .flag_w(flag_w), .cond(cond), .alu_flags(alu_flags),
    .valid_out(valid_out), .pc_src(pc_src), .reg_write(reg_write),
    .mem_write(mem_write), .cond_ex(cond_ex), .illegal(illegal),
    .flags_out(flags_out), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags [NB];     // {N,Z,C,V} per bank
  logic       e_valid, e_pc, e_rw, e_mw, e_ex, e_ill;
  int         e_cnt;

  // Even codes test a base predicate, odd codes its negation; 1110 always, 1111 never.
  function automatic bit holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c == 4'b1110);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [3:0] model_flags(input logic [1:0] b);
    return (b < NB) ? m_flags[b] : 4'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) m_flags[i] = 4'h0;
      {e_valid, e_pc, e_rw, e_mw, e_ex, e_ill} = '0;
      e_cnt = 0;
    end else begin
      bit ok, pass, bad;
      ok   = (bank_sel < NB);
      pass = ok && holds(cond, model_flags(bank_sel));
      bad  = !ok || (cond == 4'hF);
      if (flush) begin
        {e_valid, e_pc, e_rw, e_mw, e_ex, e_ill} = '0;
      end else if (stall) begin
        // everything holds
      end else if (valid_in) begin
        e_valid = 1; e_ex = pass; e_ill = bad;
        e_pc = pcs && pass; e_rw = reg_w && pass; e_mw = mem_w && pass;
        if (pass) begin
          if (flag_w[1]) m_flags[bank_sel][3:2] = alu_flags[3:2];
          if (flag_w[0]) m_flags[bank_sel][1:0] = alu_flags[1:0];
        end else if (!bad && e_cnt < (1 << CW) - 1) begin
          e_cnt++;
        end
      end else begin
        {e_valid, e_pc, e_rw, e_mw, e_ex, e_ill} = '0;
      end
    end
  end

  // Compare process: every negedge once enabled.
  always @(negedge clk) begin
    if (check_en) begin
      check("valid_out", valid_out, e_valid);
      check("pc_src", pc_src, e_pc);
      check("reg_write", reg_write, e_rw);
      check("mem_write", mem_write, e_mw);
      check("squash_cnt", squash_cnt, e_cnt);
      check("flags_out", flags_out, model_flags(bank_sel));
      if (e_valid) begin
        check("cond_ex", cond_ex, e_ex);
        check("illegal", illegal, e_ill);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] b, input logic [3:0] c, input logic p,
                       input logic r, input logic m, input logic [1:0] fw,
                       input logic [3:0] af);
    valid_in = 1; bank_sel = b; cond = c; pcs = p; reg_w = r; mem_w = m;
    flag_w = fw; alu_flags = af;
    step();
  endtask

  logic [5:0] frozen;
  logic [3:0] frozen_cnt;

  initial begin
    #2 rst = 1;
    #20 rst = 0;
    #1;
    check("reset valid_out", valid_out, 0);
    check("reset squash_cnt", squash_cnt, 0);
    check("reset flags_out", flags_out, 0);
    check_en = 1;

    // EQ on zero flags fails
    instr(0, 4'b0000, 1, 0, 0, 2'b00, 4'h0);
    check("eq fail valid", valid_out, 1);
    check("eq fail cond_ex", cond_ex, 0);
    check("eq fail pc_src", pc_src, 0);
    check("eq fail squash", squash_cnt, 1);
    // NE passes
    instr(0, 4'b0001, 0, 1, 0, 2'b00, 4'h0);
    check("ne reg_write", reg_write, 1);
    // AL writes bank0 = 0100
    instr(0, 4'b1110, 0, 0, 0, 2'b11, 4'b0100);
    check("bank0 flags", flags_out, 4'b0100);
    bank_sel = 1; #1;
    check("bank1 untouched", flags_out, 4'b0000);
    instr(0, 4'b0000, 0, 0, 0, 2'b00, 4'h0);
    check("eq bank0 pass", cond_ex, 1);
    instr(1, 4'b0000, 0, 0, 0, 2'b00, 4'h0);
    check("eq bank1 fail", cond_ex, 0);
    check("squash 2", squash_cnt, 2);
    // N,Z-only write on bank1
    instr(1, 4'b1110, 0, 0, 0, 2'b10, 4'b1111);
    check("bank1 nz only", flags_out, 4'b1100);
    instr(1, 4'b1000, 0, 0, 0, 2'b00, 4'h0);
    check("hi fail", cond_ex, 0);
    instr(1, 4'b1001, 0, 0, 0, 2'b00, 4'h0);
    check("ls pass", cond_ex, 1);
    instr(1, 4'b1011, 0, 0, 0, 2'b00, 4'h0);
    check("lt pass", cond_ex, 1);
    // reserved condition
    instr(1, 4'b1111, 0, 0, 1, 2'b11, 4'b0011);
    check("nv illegal", illegal, 1);
    check("nv mem_write", mem_write, 0);
    check("nv flags kept", flags_out, 4'b1100);
    check("nv squash kept", squash_cnt, 3);
    // out-of-range bank
    instr(3, 4'b1110, 1, 1, 1, 2'b11, 4'hF);
    check("oor illegal", illegal, 1);
    check("oor cond_ex", cond_ex, 0);
    check("oor flags_out", flags_out, 0);
    // stall for 3 cycles with a passing flag-writing instruction waiting
    instr(0, 4'b1110, 1, 1, 1, 2'b00, 4'h0);
    frozen = {valid_out, pc_src, reg_write, mem_write, cond_ex, illegal};
    frozen_cnt = squash_cnt;
    stall = 1; bank_sel = 0; cond = 4'b0000; flag_w = 2'b11; alu_flags = 4'b1010;
    repeat (3) step();
    check("stall outputs", {valid_out, pc_src, reg_write, mem_write, cond_ex, illegal}, frozen);
    check("stall flags", flags_out, 4'b0100);
    check("stall squash", squash_cnt, frozen_cnt);
    flush = 1; step();
    check("stall+flush clear", {valid_out, pc_src, reg_write, mem_write, cond_ex, illegal}, 0);
    stall = 0; flush = 0;

    // randomized phase, checked by the compare process
    for (int k = 0; k < 400; k++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 6) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      bank_sel  = 2'($urandom_range(0, 3));
      cond      = 4'($urandom);
      pcs       = 1'($urandom); reg_w = 1'($urandom); mem_w = 1'($urandom);
      flag_w    = 2'($urandom);
      alu_flags = 4'($urandom);
      step();
    end
    stall = 0; flush = 0;

    // saturation: bank2 cleared to Z=0 then 20 failing EQs
    instr(2, 4'b1110, 0, 0, 0, 2'b11, 4'b0000);
    for (int k = 0; k < 20; k++) instr(2, 4'b0000, 0, 0, 0, 2'b00, 4'h0);
    check("squash saturates", squash_cnt, 15);
    instr(2, 4'b1110, 0, 0, 0, 2'b11, 4'b0110);

    // asynchronous reset mid-sequence, away from any edge
    valid_in = 1; cond = 4'b1110; bank_sel = 2;
    #2 rst = 1;
    #1;
    check("async rst outputs", {valid_out, pc_src, reg_write, mem_write, cond_ex, illegal}, 0);
    check("async rst flags", flags_out, 0);
    check("async rst squash", squash_cnt, 0);
    valid_in = 0;
    repeat (2) step();
    rst = 0;
    repeat (3) step();

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
